rgb_to_yuv_datapath: RTL and testbench

RGB_TO_YUV_DATAPATH -- requirements
Module: rgb_to_yuv_datapath

---
 rtl/rgb_to_yuv_datapath_pkg.sv | 53 +++++
 rtl/rgb_to_yuv_pixel.sv | 28 ++
 rtl/rgb_to_yuv_datapath.sv | 148 ++++++++++++++
 tb/tb_rgb_to_yuv_datapath.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_to_yuv_datapath_pkg.sv
// Shared types, coefficients and helpers for the RGB-to-YUV pair converter.
// Conversion maths is 26-bit signed fixed point with 16 fractional bits.
package rgb_to_yuv_datapath_pkg;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned DIM_W  = 16;
  localparam int unsigned ACC_W  = 26;

  typedef logic signed [ACC_W-1:0] acc_t;

  localparam acc_t Y_R = 26'sd16843;
  localparam acc_t Y_G = 26'sd33030;
  localparam acc_t Y_B = 26'sd6423;
  localparam acc_t U_R = -26'sd9699;
  localparam acc_t U_G = -26'sd19071;
  localparam acc_t U_B = 26'sd28770;
  localparam acc_t V_R = 26'sd28770;
  localparam acc_t V_G = -26'sd24117;
  localparam acc_t V_B = -26'sd4653;

  localparam acc_t Y_OFFSET  = 26'sd16;
  localparam acc_t UV_OFFSET = 26'sd128;
  localparam acc_t ROUND     = 26'sd32768;

  typedef enum logic [3:0] {
    ST_IDLE, ST_RD0, ST_RD1, ST_RD2, ST_RD3,
    ST_CONV, ST_WRY, ST_WRU, ST_WRV, ST_DONE
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] u;
    logic [7:0] v;
  } yuv_t;

  function automatic acc_t widen(input logic [7:0] c);
    return acc_t'({{(ACC_W-8){1'b0}}, c});
  endfunction

  function automatic logic [7:0] clamp_u8(input acc_t v);
    if (v[ACC_W-1]) return 8'd0;
    else if (v > 26'sd255) return 8'hFF;
    else return v[7:0];
  endfunction

endpackage

// File: rtl/rgb_to_yuv_pixel.sv
// Combinational colour-space conversion of one RGB pixel to clamped YUV.
module rgb_to_yuv_pixel
  import rgb_to_yuv_datapath_pkg::*;
(
  input  rgb_t pix_i,
  output yuv_t yuv_o
);

  acc_t r, g, b;
  acc_t y_sum, u_sum, v_sum;

  // NOTE: every signal written here is assigned on every path, so no latch is inferred.
  always_comb begin
    r = widen(pix_i.r);
    g = widen(pix_i.g);
    b = widen(pix_i.b);

    y_sum = Y_R * r + Y_G * g + Y_B * b + ROUND;
    u_sum = U_R * r + U_G * g + U_B * b + ROUND;
    v_sum = V_R * r + V_G * g + V_B * b + ROUND;

    // Arithmetic shift floors negative chroma sums before the offset is applied.
    yuv_o.y = clamp_u8((y_sum >>> 16) + Y_OFFSET);
    yuv_o.u = clamp_u8((u_sum >>> 16) + UV_OFFSET);
    yuv_o.v = clamp_u8((v_sum >>> 16) + UV_OFFSET);
  end

endmodule

// File: rtl/rgb_to_yuv_datapath.sv
// Reads interleaved RGB pixel pairs from word memory and writes planar Y/U/V,
// one pair every eight cycles.
module rgb_to_yuv_datapath
  import rgb_to_yuv_datapath_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [DIM_W-1:0]  width_i,
  input  logic [DIM_W-1:0]  height_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic [DATA_W-1:0] r_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              busy_o,
  output logic              done_o
);

  state_t state_q, state_d;

  logic [ADDR_W-1:0] half_q, p_q, rd_base_q;
  logic [ADDR_W-1:0] y_base_q, u_base_q, v_base_q;
  rgb_t              pix0_q, pix1_q;
  yuv_t              yuv0, yuv1, yuv0_q, yuv1_q;

  logic [ADDR_W-1:0] n_in, half_in, p_inc;
  logic              last_pair;

  assign n_in      = ADDR_W'(width_i) * ADDR_W'(height_i);
  assign half_in   = n_in >> 1;
  assign p_inc     = p_q + ADDR_W'(1);
  assign last_pair = (p_inc == half_q);

  rgb_to_yuv_pixel u_pix0 (.pix_i(pix0_q), .yuv_o(yuv0));
  rgb_to_yuv_pixel u_pix1 (.pix_i(pix1_q), .yuv_o(yuv1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      half_q    <= '0;
      p_q       <= '0;
      rd_base_q <= '0;
      y_base_q  <= '0;
      u_base_q  <= '0;
      v_base_q  <= '0;
      pix0_q    <= '0;
      pix1_q    <= '0;
      yuv0_q    <= '0;
      yuv1_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          // Plane bases are frozen here so later width/height changes cannot disturb a run.
          half_q    <= half_in;
          y_base_q  <= n_in + half_in;
          u_base_q  <= n_in << 1;
          v_base_q  <= (n_in << 1) + half_in;
          p_q       <= '0;
          rd_base_q <= '0;
        end
        ST_RD1: begin
          pix0_q.g <= r_data_i[15:8];
          pix0_q.r <= r_data_i[7:0];
        end
        ST_RD2: begin
          pix1_q.r <= r_data_i[15:8];
          pix0_q.b <= r_data_i[7:0];
        end
        ST_RD3: begin
          pix1_q.b <= r_data_i[15:8];
          pix1_q.g <= r_data_i[7:0];
        end
        ST_CONV: begin
          yuv0_q <= yuv0;
          yuv1_q <= yuv1;
        end
        ST_WRV: begin
          p_q       <= p_inc;
          rd_base_q <= rd_base_q + ADDR_W'(3);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    rd_en_o  = 1'b0;
    r_addr_o = '0;
    wr_en_o  = 1'b0;
    w_addr_o = '0;
    wdata_o  = '0;
    done_o   = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) state_d = (n_in == '0) ? ST_DONE : ST_RD0;
      ST_RD0: begin
        rd_en_o  = 1'b1;
        r_addr_o = rd_base_q;
        state_d  = ST_RD1;
      end
      ST_RD1: begin
        rd_en_o  = 1'b1;
        r_addr_o = rd_base_q + ADDR_W'(1);
        state_d  = ST_RD2;
      end
      ST_RD2: begin
        rd_en_o  = 1'b1;
        r_addr_o = rd_base_q + ADDR_W'(2);
        state_d  = ST_RD3;
      end
      ST_RD3:  state_d = ST_CONV;
      ST_CONV: state_d = ST_WRY;
      ST_WRY: begin
        wr_en_o  = 1'b1;
        w_addr_o = y_base_q + p_q;
        wdata_o  = {yuv0_q.y, yuv1_q.y};
        state_d  = ST_WRU;
      end
      ST_WRU: begin
        wr_en_o  = 1'b1;
        w_addr_o = u_base_q + p_q;
        wdata_o  = {yuv0_q.u, yuv1_q.u};
        state_d  = ST_WRV;
      end
      ST_WRV: begin
        wr_en_o  = 1'b1;
        w_addr_o = v_base_q + p_q;
        wdata_o  = {yuv0_q.v, yuv1_q.v};
        state_d  = last_pair ? ST_DONE : ST_RD0;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o = (state_q != ST_IDLE) && (state_q != ST_DONE);

endmodule

// File: tb/tb_rgb_to_yuv_datapath.sv
// Scoreboard bench: stimulus pushes expected plane writes, a negedge monitor
// serves memory reads and pops/compares every write the DUT issues.
module tb_rgb_to_yuv_datapath;

  logic        clk = 1'b0;
  logic        rst_n, start, rd_en, wr_en, busy, done;
  logic [15:0] width, height, wdata;
  logic [15:0] r_data = 16'hDEAD;
  logic [17:0] r_addr, w_addr;

  always #5 clk = ~clk;

  rgb_to_yuv_datapath dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .width_i(width), .height_i(height),
    .rd_en_o(rd_en), .r_addr_o(r_addr), .r_data_i(r_data),
    .wr_en_o(wr_en), .w_addr_o(w_addr), .wdata_o(wdata),
    .busy_o(busy), .done_o(done)
  );

  typedef struct { int addr; int data; } wr_t;

  wr_t         exp_q[$];
  logic [15:0] mem [0:262143];
  logic [15:0] wr_mem [int];
  int          pr[], pg[], pb[];
  int          checks = 0, errors = 0, cyc = 0, strobes = 0;
  logic [15:0] pend = 16'h0;
  bit          pend_v = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the conversion equations in plain integer arithmetic.
  function automatic int clamp8(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction
  function automatic int y_of(input int r, input int g, input int b);
    return clamp8(((16843*r + 33030*g + 6423*b + 32768) >>> 16) + 16);
  endfunction
  function automatic int u_of(input int r, input int g, input int b);
    return clamp8(((-9699*r - 19071*g + 28770*b + 32768) >>> 16) + 128);
  endfunction
  function automatic int v_of(input int r, input int g, input int b);
    return clamp8(((28770*r - 24117*g - 4653*b + 32768) >>> 16) + 128);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t e;
    r_data = pend_v ? pend : 16'hDEAD;
    pend_v = rd_en;
    if (rd_en) pend = mem[r_addr];
    if (rd_en || wr_en) begin
      strobes++;
      check("rd_wr_exclusive", int'(rd_en && wr_en), 0);
    end
    if (wr_en) begin
      wr_mem[int'(w_addr)] = wdata;
      check("write_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("w_addr", int'(w_addr), e.addr);
        check("wdata", int'(wdata), e.data);
      end
    end
  end

  task automatic alloc(input int n);
    pr = new[n]; pg = new[n]; pb = new[n];
  endtask

  task automatic fill_random(input int n);
    alloc(n);
    for (int i = 0; i < n; i++) begin
      pr[i] = $urandom_range(0, 255);
      pg[i] = $urandom_range(0, 255);
      pb[i] = $urandom_range(0, 255);
    end
  endtask

  task automatic fill_const(input int n, input int c);
    alloc(n);
    for (int i = 0; i < n; i++) begin
      pr[i] = c; pg[i] = c; pb[i] = c;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, int'(rd_en), 0);
    check({tag, "_wr_en"}, int'(wr_en), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_r_addr"}, int'(r_addr), 0);
    check({tag, "_w_addr"}, int'(w_addr), 0);
    check({tag, "_wdata"}, int'(wdata), 0);
  endtask

  task automatic run_image(input int w, input int h, input bit restart, input int abort_at);
    int  n, seen, rel, base, start_edge, done_w;
    wr_t e;
    n = (w * h) % 262144;
    for (int p = 0; p < n/2; p++) begin
      mem[3*p]   = 16'((pg[2*p]   << 8) | pr[2*p]);
      mem[3*p+1] = 16'((pr[2*p+1] << 8) | pb[2*p]);
      mem[3*p+2] = 16'((pb[2*p+1] << 8) | pg[2*p+1]);
      e.addr = 3*n/2 + p;
      e.data = (y_of(pr[2*p], pg[2*p], pb[2*p]) << 8) | y_of(pr[2*p+1], pg[2*p+1], pb[2*p+1]);
      exp_q.push_back(e);
      e.addr = 2*n + p;
      e.data = (u_of(pr[2*p], pg[2*p], pb[2*p]) << 8) | u_of(pr[2*p+1], pg[2*p+1], pb[2*p+1]);
      exp_q.push_back(e);
      e.addr = 5*n/2 + p;
      e.data = (v_of(pr[2*p], pg[2*p], pb[2*p]) << 8) | v_of(pr[2*p+1], pg[2*p+1], pb[2*p+1]);
      exp_q.push_back(e);
    end

    @(negedge clk);
    width = 16'(w); height = 16'(h); start = 1'b1;
    start_edge = cyc + 1;
    seen = -1;
    for (int t = 0; t <= 4*n + 16 && seen < 0; t++) begin
      @(negedge clk);
      rel = cyc - start_edge;
      start  = restart && (rel == 3 || rel == 9);
      width  = 16'($urandom);
      height = 16'($urandom);
      if (rel == 0 && n > 0) check("busy_after_start", int'(busy), 1);
      if (rel == abort_at) begin
        done_w = 0;
        for (int q = 0; q < n/2; q++)
          for (int k = 5; k <= 7; k++)
            if (8*q + k < abort_at) done_w++;
        check("pending_writes_at_abort", exp_q.size(), 3*(n/2) - done_w);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        exp_q.delete();
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = strobes;
        repeat (20) @(negedge clk);
        check("no_activity_after_abort", strobes - base, 0);
        check("idle_after_abort", int'(busy), 0);
        return;
      end
      if (done) seen = rel;
    end
    check("done_cycle", seen, 4*n);
    if (restart) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", int'(done), 0);
    check("busy_after_done", int'(busy), 0);
    check("writes_outstanding", exp_q.size(), 0);
    if (restart) begin
      base = strobes;
      repeat (4) @(negedge clk);
      check("start_at_done_ignored", strobes - base, 0);
    end
  endtask

  initial begin
    int base;
    int dims [6][2] = '{'{2, 3}, '{3, 2}, '{4, 4}, '{5, 6}, '{8, 8}, '{1, 2}};
    rst_n = 1'b0; start = 1'b0; width = '0; height = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;

    // Red then blue pixel.
    alloc(2);
    pr[0] = 255; pg[0] = 0; pb[0] = 0;
    pr[1] = 0;   pg[1] = 0; pb[1] = 255;
    run_image(2, 1, 1'b0, -1);
    check("red_blue_y", int'(wr_mem[3]), 'h5229);
    check("red_blue_u", int'(wr_mem[4]), 'h5AF0);
    check("red_blue_v", int'(wr_mem[5]), 'hF06E);

    fill_const(2, 255);
    run_image(2, 1, 1'b0, -1);
    check("white_y", int'(wr_mem[3]), 'hEBEB);
    check("white_u", int'(wr_mem[4]), 'h8080);
    check("white_v", int'(wr_mem[5]), 'h8080);

    fill_const(2, 0);
    run_image(2, 1, 1'b0, -1);
    check("black_y", int'(wr_mem[3]), 'h1010);
    check("black_u", int'(wr_mem[4]), 'h8080);
    check("black_v", int'(wr_mem[5]), 'h8080);

    alloc(8);
    for (int i = 0; i < 8; i++) begin
      pr[i] = i * 32; pg[i] = 255 - i * 32; pb[i] = (i * 77) % 256;
    end
    run_image(4, 2, 1'b0, -1);

    fill_random(8);
    run_image(4, 2, 1'b1, -1);

    base = strobes;
    alloc(0);
    run_image(0, 5, 1'b0, -1);
    check("zero_width_no_strobes", strobes - base, 0);

    fill_random(4);
    run_image(2, 2, 1'b0, 12);
    fill_random(4);
    run_image(2, 2, 1'b0, -1);

    for (int d = 0; d < 6; d++) begin
      fill_random(dims[d][0] * dims[d][1]);
      run_image(dims[d][0], dims[d][1], 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
